delay_ram_responder: RTL and testbench

- Clocked responder for the delay-line sample memory: it is the memory side of the address/data/WE/OE bus driven by the delay RAM interface.
- Replaces the combinational RAM model with a registered, handshaked store.
- Adds programmable access wait states, a post-reset memory clear sweep, and a read-before-write mode, so the delay-line write/read pair completes in one transaction.

---
 rtl/delay_ram_responder_if.sv | 34 +++
 rtl/delay_ram_responder.sv | 197 +++++++++++++++++++
 tb/tb_delay_ram_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/delay_ram_responder_if.sv
// Bus between the delay RAM interface (master) and its sample memory
// responder (slave).
//   req      master -> slave  request strobe, four-phase handshake
//   address  master -> slave  sample address
//   WE / OE  master -> slave  write / read enables, qualified by req
//   wdata    master -> slave  write sample
//   rdata    slave -> master  registered read sample
//   ack      slave -> master  one-cycle transaction-complete pulse
//   busy     slave -> master  responder not in IDLE
//   err      slave -> master  one-cycle pulse with ack when neither WE nor OE
interface delay_ram_responder_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic              req;
   logic [ADDR_W-1:0] address;
   logic              WE;
   logic              OE;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              busy;
   logic              err;

   modport master (
      output req, address, WE, OE, wdata,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, address, WE, OE, wdata,
      output rdata, ack, busy, err
   );
endinterface

// File: rtl/delay_ram_responder.sv
// Registered, handshaked sample memory for the delay line.
// After reset the whole memory is swept to zero, then requests are served
// with WAIT_CYCLES access wait states. WE and OE together perform a
// read-before-write: old sample is returned and new sample stored on the
// same edge.
// Ports:
//   clk  system clock (sample-rate domain)
//   rst  asynchronous reset, active-high
//   bus  slave side of delay_ram_responder_if
//
// state   | meaning
// --------+-----------------------------------------------------------
// CLEAR   | writing zero to mem[ptr], one address per clock
// IDLE    | waiting for a fresh request (req high after req seen low)
// ACCESS  | counting down access wait states
// RESPOND | ack (and err) high for one cycle; commit already done
module delay_ram_responder #(
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   delay_ram_responder_if.slave bus
);

   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int WAIT_M1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0]        WAIT_LD  = 4'(WAIT_M1);
   localparam logic [ADDR_W-1:0] LAST_PTR = '1;

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      IDLE    = 2'd1,
      ACCESS  = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                req_low_q, req_low_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic                oe_q, oe_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   logic                commit;
   logic [ADDR_W-1:0]   acc_addr;
   logic                acc_we;
   logic                acc_oe;
   logic [DATA_W-1:0]   acc_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         ptr_q     <= '0;
         cnt_q     <= '0;
         req_low_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         oe_q      <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         req_low_q <= req_low_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         oe_q      <= oe_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   // Memory has no reset; reset only gates the write so an aborted
   // transaction can never land.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      req_low_d = req_low_q;
      addr_d    = addr_q;
      we_d      = we_q;
      oe_d      = oe_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      commit    = 1'b0;

      // With zero wait states the commit happens on the accept edge itself,
      // so the live bus values are used instead of the latched copy.
      if (state_q == IDLE) begin
         acc_addr  = bus.address;
         acc_we    = bus.WE;
         acc_oe    = bus.OE;
         acc_wdata = bus.wdata;
      end else begin
         acc_addr  = addr_q;
         acc_we    = we_q;
         acc_oe    = oe_q;
         acc_wdata = wdata_q;
      end

      if (!bus.req) begin
         req_low_d = 1'b1;
      end

      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (bus.req && req_low_q) begin
               req_low_d = 1'b0;
               addr_d    = bus.address;
               we_d      = bus.WE;
               oe_d      = bus.OE;
               wdata_d   = bus.wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESPOND;
                  commit  = 1'b1;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESPOND;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase

      // Read uses the pre-edge memory contents, so WE+OE returns the old
      // sample while the new one is written on the same edge.
      if (commit) begin
         ack_d = 1'b1;
         err_d = !acc_we && !acc_oe;
         if (acc_oe) begin
            rdata_d = mem[acc_addr];
         end
         if (acc_we) begin
            mem_we    = 1'b1;
            mem_waddr = acc_addr;
            mem_wdata = acc_wdata;
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_delay_ram_responder.sv
module tb_delay_ram_responder;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;
   localparam int WAIT_C = 2;
   localparam int LAT    = WAIT_C + 1;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      int                lat;
   } exp_t;

   logic clk;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t sb[$];

   delay_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   delay_ram_responder #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .WAIT_CYCLES(WAIT_C)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request from a negedge and waits (bounded) for ack.
   // Bus inputs other than req are scrambled after the accept edge.
   task automatic drive_req(input logic [ADDR_W-1:0] a, input logic we, input logic oe,
                            input logic [DATA_W-1:0] wd, input bit keep_high,
                            output logic [DATA_W-1:0] rd, output logic er,
                            output int lat);
      bit to;
      bus.address = a;
      bus.WE      = we;
      bus.OE      = oe;
      bus.wdata   = wd;
      bus.req     = 1'b1;
      lat = 0;
      to  = 1'b1;
      rd  = 'x;
      er  = 1'bx;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         bus.address = ADDR_W'($urandom);
         bus.wdata   = DATA_W'($urandom);
         bus.WE      = 1'($urandom);
         bus.OE      = 1'($urandom);
         if (bus.ack) begin
            to = 1'b0;
            rd = bus.rdata;
            er = bus.err;
            break;
         end
      end
      if (to) lat = -1;
      if (!keep_high) bus.req = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int n;
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      exp_t e;
      rst = 1'b1;
      bus.req = 1'b0; bus.address = '0; bus.WE = 1'b0; bus.OE = 1'b0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", bus.ack); else pass_cnt++;
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err); else pass_cnt++;
      total_cnt++; if (bus.rdata !== 16'h0000) $display("FAIL reset_rdata got %h exp 0000", bus.rdata); else pass_cnt++;
      rst = 1'b0;
      count_busy(n);
      total_cnt++; if (n !== 8) $display("FAIL clear_len got %0d exp 8", n); else pass_cnt++;
      for (int a = 0; a < 8; a++) begin
         sb.push_back('{16'h0000, 1'b0, LAT});
         drive_req(ADDR_W'(a), 1'b0, 1'b1, 16'hFFFF, 1'b0, rd, er, lat);
         e = sb.pop_front();
         total_cnt++; if (rd !== e.rdata) $display("FAIL clear_rd%0d got %h exp %h", a, rd, e.rdata); else pass_cnt++;
         total_cnt++; if (er !== e.err) $display("FAIL clear_err%0d got %b exp %b", a, er, e.err); else pass_cnt++;
         total_cnt++; if (lat !== e.lat) $display("FAIL clear_lat%0d got %0d exp %0d", a, lat, e.lat); else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_write();
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      exp_t e;
      sb.push_back('{16'h0000, 1'b0, LAT});
      drive_req(3'd5, 1'b1, 1'b0, 16'h1234, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL write_rdata_held got %h exp %h", rd, e.rdata); else pass_cnt++;
      total_cnt++; if (er !== e.err) $display("FAIL write_err got %b exp %b", er, e.err); else pass_cnt++;
      total_cnt++; if (lat !== e.lat) $display("FAIL write_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
      @(negedge clk);
      sb.push_back('{16'h1234, 1'b0, LAT});
      drive_req(3'd5, 1'b0, 1'b1, 16'h0000, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL write_readback got %h exp %h", rd, e.rdata); else pass_cnt++;
      total_cnt++; if (lat !== e.lat) $display("FAIL write_readback_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_rbw();
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      exp_t e;
      sb.push_back('{16'h1234, 1'b0, LAT});
      drive_req(3'd5, 1'b1, 1'b1, 16'hBEEF, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL rbw_old got %h exp %h", rd, e.rdata); else pass_cnt++;
      total_cnt++; if (er !== e.err) $display("FAIL rbw_err got %b exp %b", er, e.err); else pass_cnt++;
      @(negedge clk);
      sb.push_back('{16'hBEEF, 1'b0, LAT});
      drive_req(3'd5, 1'b0, 1'b1, 16'h0000, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL rbw_new got %h exp %h", rd, e.rdata); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_err();
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      exp_t e;
      sb.push_back('{16'hBEEF, 1'b1, LAT});
      drive_req(3'd3, 1'b0, 1'b0, 16'h7777, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (er !== e.err) $display("FAIL err_pulse got %b exp %b", er, e.err); else pass_cnt++;
      total_cnt++; if (rd !== e.rdata) $display("FAIL err_rdata_held got %h exp %h", rd, e.rdata); else pass_cnt++;
      total_cnt++; if (lat !== e.lat) $display("FAIL err_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_one_cycle got %b exp 0", bus.err); else pass_cnt++;
      total_cnt++; if (bus.ack !== 1'b0) $display("FAIL ack_one_cycle got %b exp 0", bus.ack); else pass_cnt++;
      sb.push_back('{16'h0000, 1'b0, LAT});
      drive_req(3'd3, 1'b0, 1'b1, 16'h0000, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL err_mem_untouched got %h exp %h", rd, e.rdata); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_hold();
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      int acks;
      exp_t e;
      sb.push_back('{16'hBEEF, 1'b0, LAT});
      drive_req(3'd5, 1'b0, 1'b1, 16'h0000, 1'b1, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL hold_first got %h exp %h", rd, e.rdata); else pass_cnt++;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ack) acks++;
      end
      total_cnt++; if (acks !== 0) $display("FAIL hold_extra_acks got %0d exp 0", acks); else pass_cnt++;
      bus.req = 1'b0;
      @(negedge clk);
      sb.push_back('{16'h0000, 1'b0, LAT});
      drive_req(3'd2, 1'b0, 1'b1, 16'h0000, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (lat !== e.lat) $display("FAIL hold_rearm_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
      total_cnt++; if (rd !== e.rdata) $display("FAIL hold_rearm_rd got %h exp %h", rd, e.rdata); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] rd;
      logic er;
      int lat;
      int acks;
      int n;
      exp_t e;
      bus.address = 3'd2; bus.WE = 1'b1; bus.OE = 1'b0; bus.wdata = 16'h5555; bus.req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_in_access got %b exp 1", bus.busy); else pass_cnt++;
      rst = 1'b1;
      bus.req = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.ack) acks++;
      end
      rst = 1'b0;
      count_busy(n);
      total_cnt++; if (n !== 8) $display("FAIL mid_clear_len got %0d exp 8", n); else pass_cnt++;
      total_cnt++; if (acks !== 0) $display("FAIL mid_no_ack got %0d exp 0", acks); else pass_cnt++;
      sb.push_back('{16'h0000, 1'b0, LAT});
      drive_req(3'd2, 1'b0, 1'b1, 16'h0000, 1'b0, rd, er, lat);
      e = sb.pop_front();
      total_cnt++; if (rd !== e.rdata) $display("FAIL mid_not_committed got %h exp %h", rd, e.rdata); else pass_cnt++;
      total_cnt++; if (lat !== e.lat) $display("FAIL mid_lat got %0d exp %0d", lat, e.lat); else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_rbw();
      test_err();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
